// File: rtl/if_id_stage_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_stage_ctrl
//
// Purpose
//   Fetch-side pipeline control. This block owns the program counter and the
//   IF/ID pipeline register, and it consumes the hazard unit's Stall and
//   IF_ID_Flush outputs:
//     - On a load-use stall, the PC and the IF/ID register hold their values.
//     - When a branch is taken in EX or a jump is decoded in ID, fetch is
//       redirected to the target address.
//     - On a flush, a NOP bubble is written into IF/ID.
//   The block sits between the instruction memory and the ID stage. The
//   memory read is combinational: IMEM_data is a function of IMEM_addr
//   within the same cycle.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//   NOP_INSTR       bubble instruction written on flush/reset (ADDI x0,x0,0)
//   REG_DATA_WIDTH  PC / instruction width
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-high reset
//   Stall            in   load-use stall from the hazard unit
//   IF_ID_Flush      in   flush IF/ID (branch or jump taken)
//   EX_PC_Branch     in   branch taken, resolved in EX
//   EX_Branch_target in   branch target address
//   ID_Jump          in   jump decoded in ID
//   ID_Jump_target   in   jump target address
//   IMEM_addr        out  instruction memory address (current PC)
//   IMEM_data        in   instruction word read from IMEM_addr
//   IF_Instruction   out  fetched word, fed back to the hazard unit
//   ID_Instruction   out  IF/ID registered instruction
//   ID_PC            out  IF/ID registered PC
//   ID_PC_plus4      out  IF/ID registered PC+4
//   ID_Valid         out  IF/ID holds a real (non-bubble) instruction
//   Stall_count      out  stall cycles seen (performance counter)
//   Flush_count      out  flush cycles seen (performance counter)
//
// Configuration
//   IF_ID_PERF_CNT_EN  When this macro is defined, two saturating 32-bit
//                      performance counters are built. When it is
//                      undefined, no counter flops exist and Stall_count
//                      and Flush_count are tied to zero.
// ---------------------------------------------------------------------------
module if_id_stage_ctrl #(
    parameter int                        REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0] RESET_PC       = 32'h0000_0000,
    parameter logic [REG_DATA_WIDTH-1:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Stall,
    input  logic                      IF_ID_Flush,
    input  logic                      EX_PC_Branch,
    input  logic [REG_DATA_WIDTH-1:0] EX_Branch_target,
    input  logic                      ID_Jump,
    input  logic [REG_DATA_WIDTH-1:0] ID_Jump_target,
    output logic [REG_DATA_WIDTH-1:0] IMEM_addr,
    input  logic [REG_DATA_WIDTH-1:0] IMEM_data,
    output logic [REG_DATA_WIDTH-1:0] IF_Instruction,
    output logic [REG_DATA_WIDTH-1:0] ID_Instruction,
    output logic [REG_DATA_WIDTH-1:0] ID_PC,
    output logic [REG_DATA_WIDTH-1:0] ID_PC_plus4,
    output logic                      ID_Valid,
    output logic [31:0]               Stall_count,
    output logic [31:0]               Flush_count
);

    // -----------------------------------------------------------------------
    // Program counter and its successor
    // -----------------------------------------------------------------------
    logic [REG_DATA_WIDTH-1:0] pc;
    logic [REG_DATA_WIDTH-1:0] pc_plus4;
    logic [REG_DATA_WIDTH-1:0] pc_next;
    logic [REG_DATA_WIDTH-1:0] branch_target_aligned;
    logic [REG_DATA_WIDTH-1:0] jump_target_aligned;

    // The addition is truncated to the register width, so PC+4 wraps
    // naturally from the top word of the address space back to zero.
    assign pc_plus4 = pc + REG_DATA_WIDTH'(4);

    // Instructions are word aligned, so the two low bits of any redirect
    // target are discarded instead of being trusted from upstream.
    assign branch_target_aligned = {EX_Branch_target[REG_DATA_WIDTH-1:2], 2'b00};
    assign jump_target_aligned   = {ID_Jump_target[REG_DATA_WIDTH-1:2], 2'b00};

    // Next-PC selection. The branch in EX belongs to an older instruction
    // than the jump in ID, so the branch takes priority when both occur.
    // A redirect also takes priority over a stall: the stalled instruction
    // is on the wrong path and is discarded.
    always_comb begin
        pc_next = pc_plus4;
        if (EX_PC_Branch) begin
            pc_next = branch_target_aligned;
        end else if (ID_Jump) begin
            pc_next = jump_target_aligned;
        end else if (Stall) begin
            pc_next = pc;
        end
    end

    // PC register. Reset acts immediately, so fetch restarts at RESET_PC
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // The instruction memory is addressed directly by the PC. The fetched
    // word is also returned to the hazard unit so it can detect load-use
    // hazards against the instruction in ID.
    assign IMEM_addr      = pc;
    assign IF_Instruction = IMEM_data;

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    logic [REG_DATA_WIDTH-1:0] id_instruction_q;
    logic [REG_DATA_WIDTH-1:0] id_pc_q;
    logic [REG_DATA_WIDTH-1:0] id_pc_plus4_q;
    logic                      id_valid_q;

    // A flush takes priority over a stall. It replaces only the instruction
    // with a bubble and clears the valid bit. The PC fields keep their old
    // values because nothing downstream uses them for an invalid slot.
    // A stall freezes every field so that ID repeats the same instruction.
    // Otherwise the word fetched this cycle is captured together with its
    // address and return address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instruction_q <= NOP_INSTR;
            id_pc_q          <= '0;
            id_pc_plus4_q    <= '0;
            id_valid_q       <= 1'b0;
        end else if (IF_ID_Flush) begin
            id_instruction_q <= NOP_INSTR;
            id_valid_q       <= 1'b0;
        end else if (!Stall) begin
            id_instruction_q <= IMEM_data;
            id_pc_q          <= pc;
            id_pc_plus4_q    <= pc_plus4;
            id_valid_q       <= 1'b1;
        end
    end

    assign ID_Instruction = id_instruction_q;
    assign ID_PC          = id_pc_q;
    assign ID_PC_plus4    = id_pc_plus4_q;
    assign ID_Valid       = id_valid_q;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_q;
    logic        stall_event;
    logic        flush_event;

    // A stall that coincides with a flush never freezes IF/ID, so it is not
    // counted as a stall cycle. A flush is counted once per asserted cycle,
    // even when a branch and a jump redirect in the same cycle.
    assign stall_event = Stall && !IF_ID_Flush;
    assign flush_event = IF_ID_Flush;

    // Both counters saturate at all-ones rather than wrapping, so a long
    // run never reads back as a small count. Only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall_event && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (flush_event && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign Stall_count = stall_count_q;
    assign Flush_count = flush_count_q;
`else
    // The counters are not built in this configuration.
    assign Stall_count = '0;
    assign Flush_count = '0;
`endif

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_ctrl
//
// Directed testbench for if_id_stage_ctrl. The instruction memory is
// modelled as a combinational function of the address:
//   word(addr) = 32'hA000_0000 ^ addr
// With this model, every expected instruction word can be written down by
// hand from its address.
// Counter expectations depend on IF_ID_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_if_id_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        IF_ID_Flush;
    logic        EX_PC_Branch;
    logic [31:0] EX_Branch_target;
    logic        ID_Jump;
    logic [31:0] ID_Jump_target;
    logic [31:0] IMEM_addr;
    logic [31:0] IMEM_data;
    logic [31:0] IF_Instruction;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC_plus4;
    logic        ID_Valid;
    logic [31:0] Stall_count;
    logic [31:0] Flush_count;

    int errorCount = 0;
    int checkCount = 0;

    if_id_stage_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .Stall            (Stall),
        .IF_ID_Flush      (IF_ID_Flush),
        .EX_PC_Branch     (EX_PC_Branch),
        .EX_Branch_target (EX_Branch_target),
        .ID_Jump          (ID_Jump),
        .ID_Jump_target   (ID_Jump_target),
        .IMEM_addr        (IMEM_addr),
        .IMEM_data        (IMEM_data),
        .IF_Instruction   (IF_Instruction),
        .ID_Instruction   (ID_Instruction),
        .ID_PC            (ID_PC),
        .ID_PC_plus4      (ID_PC_plus4),
        .ID_Valid         (ID_Valid),
        .Stall_count      (Stall_count),
        .Flush_count      (Flush_count)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    assign IMEM_data = 32'hA000_0000 ^ IMEM_addr;

`ifdef IF_ID_PERF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one set of control inputs, lets one rising edge pass, and then
    // waits #1 so that outputs are sampled away from the edge.
    task automatic applyStimulus(input logic stall, input logic flush,
                                 input logic br, input logic [31:0] brT,
                                 input logic jmp, input logic [31:0] jmpT);
        Stall            = stall;
        IF_ID_Flush      = flush;
        EX_PC_Branch     = br;
        EX_Branch_target = brT;
        ID_Jump          = jmp;
        ID_Jump_target   = jmpT;
        @(posedge clk);
        #1;
    endtask

    // Checks the full IF/ID register contents and the current PC.
    task automatic checkId(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic valid, input logic [31:0] imemAddr);
        checkOutput({tag, ".instr"}, ID_Instruction, instr);
        checkOutput({tag, ".pc"},    ID_PC, pc);
        checkOutput({tag, ".pc4"},   ID_PC_plus4, pc4);
        checkOutput({tag, ".valid"}, {31'd0, ID_Valid}, {31'd0, valid});
        checkOutput({tag, ".addr"},  IMEM_addr, imemAddr);
    endtask

    task automatic checkCounters(input string tag, input logic [31:0] stalls,
                                 input logic [31:0] flushes);
        checkOutput({tag, ".stallCnt"}, Stall_count, CntEn ? stalls : 32'd0);
        checkOutput({tag, ".flushCnt"}, Flush_count, CntEn ? flushes : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        Stall = 1'b0; IF_ID_Flush = 1'b0; EX_PC_Branch = 1'b0; ID_Jump = 1'b0;
        EX_Branch_target = '0; ID_Jump_target = '0;
        #2;
        checkId("reset", 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'h0);
        checkCounters("reset", 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;

        // Free-running fetch: A at address 0, then B at address 4.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("run0", 32'hA000_0000, 32'h0, 32'h4, 1'b1, 32'h4);
        checkOutput("run0.ifInstr", IF_Instruction, 32'hA000_0004);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("run1", 32'hA000_0004, 32'h4, 32'h8, 1'b1, 32'h8);

        // Two stall cycles with PC=8: everything holds.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkId("stall0", 32'hA000_0004, 32'h4, 32'h8, 1'b1, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkId("stall1", 32'hA000_0004, 32'h4, 32'h8, 1'b1, 32'h8);
        checkCounters("stall1", 2, 0);

        // Release the stall: C at address 8 enters ID.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("run2", 32'hA000_0008, 32'h8, 32'hC, 1'b1, 32'hC);

        // Branch to 0x100 with flush: a bubble enters ID and the PC fields hold.
        applyStimulus(0, 1, 1, 32'h100, 0, 0);
        checkId("branch", 32'h0000_0013, 32'h8, 32'hC, 1'b0, 32'h100);
        checkCounters("branch", 2, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("brTarget", 32'hA000_0100, 32'h100, 32'h104, 1'b1, 32'h104);

        // Branch, jump, and stall together. The branch wins, its target is
        // realigned, and only the flush is counted.
        applyStimulus(1, 1, 1, 32'h303, 1, 32'h200);
        checkId("brJmp", 32'h0000_0013, 32'h100, 32'h104, 1'b0, 32'h300);
        checkCounters("brJmp", 2, 2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("brJmpTgt", 32'hA000_0300, 32'h300, 32'h304, 1'b1, 32'h304);

        // A jump alone overrides a stall, and its target is realigned.
        applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFE);
        checkOutput("jmp.addr", IMEM_addr, 32'hFFFF_FFFC);
        checkCounters("jmp", 2, 3);

        // Fetching from the last word: PC+4 wraps to zero.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("wrap", 32'h5FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
        checkOutput("wrap.ifInstr", IF_Instruction, 32'hA000_0000);

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("run3", 32'hA000_0004, 32'h4, 32'h8, 1'b1, 32'h8);

        // Assert reset mid-cycle during a stall with a branch pending. The
        // outputs must clear before the next clock edge.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkCounters("preRst", 3, 3);
        EX_PC_Branch = 1'b1;
        EX_Branch_target = 32'h500;
        #1;
        rst = 1'b1;
        #1;
        checkId("asyncRst", 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'h0);
        checkCounters("asyncRst", 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        Stall = 1'b0; EX_PC_Branch = 1'b0;
        rst = 1'b0;

        // Fetch restarts at RESET_PC.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkId("restart", 32'hA000_0000, 32'h0, 32'h4, 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
